// File: rtl/cpu_pkg.sv
// Shared CPU constants.
//   CPU_DATA_W : default register width
//   CPU_ADDR_W : default register address width
//   REG_ZERO   : index of the register that can be hardwired to zero
package cpu_pkg;

    localparam int CPU_DATA_W = 32;
    localparam int CPU_ADDR_W = 5;
    localparam int REG_ZERO   = 0;

endpackage

// File: rtl/regfile_decoded_if.sv
// Register file access bundle between decode/write-back and the register file.
//   wen/waddr/wdata      : write-back port (driven by master)
//   raddr1/raddr2        : read addresses (driven by master)
//   rdata1/rdata2        : combinational read data (driven by slave)
//   wr_onehot/reg_valid  : write status (driven by slave)
interface regfile_decoded_if
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int NUM_REGS = 32
) ();

    logic                wen;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [ADDR_W-1:0]   raddr1;
    logic [ADDR_W-1:0]   raddr2;
    logic [DATA_W-1:0]   rdata1;
    logic [DATA_W-1:0]   rdata2;
    logic [NUM_REGS-1:0] wr_onehot;
    logic [NUM_REGS-1:0] reg_valid;

    modport master (
        output wen, waddr, wdata, raddr1, raddr2,
        input  rdata1, rdata2, wr_onehot, reg_valid
    );

    modport slave (
        input  wen, waddr, wdata, raddr1, raddr2,
        output rdata1, rdata2, wr_onehot, reg_valid
    );

endinterface

// File: rtl/onehot_decoder.sv
// Generic IN_W-to-OUT_N one-hot decoder, purely combinational.
//   in  : binary index
//   en  : enable; 0 forces an all-zero output
//   out : bit in set when en=1 and in < OUT_N, otherwise all zero
module onehot_decoder #(
    parameter int IN_W  = 5,
    parameter int OUT_N = 32
) (
    input  logic [IN_W-1:0]  in,
    input  logic             en,
    output logic [OUT_N-1:0] out
);

    // Indices >= OUT_N have no output bit, so they decode to all zero.
    generate
        for (genvar gi = 0; gi < OUT_N; gi++) begin : g_bit
            assign out[gi] = en && (in == IN_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/regfile_decoded.sv
// Parametrised register file with decoder-steered writes and two
// combinational read ports.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of regfile_decoded_if (write port, two read
//              ports, last-write one-hot and written-since-reset bitmap)
module regfile_decoded
    import cpu_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int NUM_REGS = 32,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_decoded_if.slave bus
);

    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0] dec_out;
    logic [NUM_REGS-1:0] wr_sel;
    logic [NUM_REGS-1:0] valid_w;
    logic [NUM_REGS-1:0] wr_onehot_reg;
    logic [DATA_W-1:0]   reg_file [NUM_REGS];
    logic                wr_accept;
    logic [ADDR_W-1:0]   raddr_p [2];
    logic [DATA_W-1:0]   rdata_p [2];

    // Gating with rst keeps a write issued during reset from reaching the
    // bypass path, so reads return 0 for the whole reset interval.
    onehot_decoder #(
        .IN_W  (ADDR_W),
        .OUT_N (NUM_REGS)
    ) u_dec (
        .in  (bus.waddr),
        .en  (bus.wen & ~rst),
        .out (dec_out)
    );

    always_comb begin
        wr_sel = dec_out;
        if (ZERO_REG != 0) begin
            wr_sel[REG_ZERO] = 1'b0;
        end
    end

    assign wr_accept = |wr_sel;

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [DATA_W-1:0] data_reg;
            logic              valid_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg  <= '0;
                    valid_reg <= (ZERO_REG != 0) && (gi == REG_ZERO);
                end else if (wr_sel[gi]) begin
                    data_reg  <= bus.wdata;
                    valid_reg <= 1'b1;
                end
            end

            assign reg_file[gi] = data_reg;
            assign valid_w[gi]  = valid_reg;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_onehot_reg <= '0;
        end else begin
            wr_onehot_reg <= wr_sel;
        end
    end

    assign raddr_p[0] = bus.raddr1;
    assign raddr_p[1] = bus.raddr2;

    // Read mux priority: out of range, hardwired zero, bypass, stored value.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] rd;

            always_comb begin
                rd = '0;
                if ({1'b0, raddr_p[gi]} >= NUM_REGS_W) begin
                    rd = '0;
                end else if ((ZERO_REG != 0) && (raddr_p[gi] == ADDR_W'(REG_ZERO))) begin
                    rd = '0;
                end else if ((BYPASS != 0) && wr_accept && (bus.waddr == raddr_p[gi])) begin
                    rd = bus.wdata;
                end else begin
                    rd = reg_file[raddr_p[gi]];
                end
            end

            assign rdata_p[gi] = rd;
        end
    endgenerate

    assign bus.rdata1    = rdata_p[0];
    assign bus.rdata2    = rdata_p[1];
    assign bus.wr_onehot = wr_onehot_reg;
    assign bus.reg_valid = valid_w;

endmodule
